// File: rtl/debounce_scanner.sv
// debounce_scanner
//
// Time-multiplexed debounce controller. One 4-sample stability evaluator is
// shared across all channels. A prescaled tick starts a round-robin scan
// that visits one channel per clock. When a channel's last four samples all
// agree and differ from its filtered level, the filtered level flips and an
// event {channel, level} is queued in a small FIFO.
//
// Ports:
//   Clock          system clock, single domain
//   Reset          asynchronous, active-high reset
//   I              raw asynchronous inputs, one bit per channel
//   O              debounced levels
//   EventValid     event FIFO is non-empty
//   EventReady     consumer accepts the head event
//   EventChannel   channel index of the head event
//   EventLevel     new filtered level of the head event
//   Overflow       sticky flag, an event was dropped because the FIFO was full
//   OverflowClear  synchronous clear of Overflow (a same-cycle set wins)

module debounce_scanner #(
    parameter int Channels        = 8,
    parameter int ClockPeriod_ns  = 20,
    parameter int FilterPeriod_ns = 500_000,
    parameter int FifoDepth       = 4
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [Channels-1:0]         I,
    output logic [Channels-1:0]         O,
    output logic                        EventValid,
    input  logic                        EventReady,
    output logic [$clog2(Channels)-1:0] EventChannel,
    output logic                        EventLevel,
    output logic                        Overflow,
    input  logic                        OverflowClear
);

    // Four samples make up one filter period, so the sample period is a third
    // of the filter time. It is never shorter than one full scan.
    localparam int Prescale = FilterPeriod_ns / ClockPeriod_ns / 3;
    localparam int Period   = (Prescale > Channels) ? Prescale : Channels;
    localparam int CntW     = $clog2(Period);
    localparam int IdxW     = $clog2(Channels);
    localparam int PtrW     = $clog2(FifoDepth);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IdxW-1:0]     idx;
    logic [IdxW-1:0]     idx_next;
    logic                scan_start;
    logic                pending;
    logic [CntW-1:0]     count;
    logic                tick;
    logic [Channels-1:0] sync1;
    logic [Channels-1:0] sync2;
    logic [3:0]          hist [Channels];
    logic [3:0]          hnew;
    logic                active;
    logic                fall;
    logic                rise;
    logic                push;

    logic [IdxW-1:0]      fifo_ch [FifoDepth];
    logic [FifoDepth-1:0] fifo_lvl;
    logic [PtrW-1:0]      rdptr;
    logic [PtrW-1:0]      wrptr;
    logic [PtrW:0]        used;
    logic                 full;
    logic                 pop;
    logic                 accept;
    logic                 drop;

    // Two-flop synchronizer. It resets to ones so idle inputs cause no events.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= I;
            sync2 <= sync1;
        end
    end

    // Free-running sample prescaler. The tick is high in the cycle where the
    // count sits at its last value.
    assign tick = (count == CntW'(Period - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CntW'(1);
        end
    end

    // Scan sequencing. A tick that arrives in the last scan cycle restarts the
    // scan directly, just like a tick that was already pending.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        scan_start = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = SCAN;
                    idx_next   = '0;
                    scan_start = 1'b1;
                end
            end
            SCAN: begin
                if (idx == IdxW'(Channels - 1)) begin
                    if (pending || tick) begin
                        idx_next   = '0;
                        scan_start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    idx_next = idx + IdxW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (scan_start) begin
                pending <= 1'b0;
            end else if (tick && (state == SCAN)) begin
                pending <= 1'b1;
            end
        end
    end

    // Shared evaluator for the channel that is currently being scanned.
    assign active = (state == SCAN);
    assign hnew   = {hist[idx][2:0], sync2[idx]};
    assign fall   = active && (hnew == 4'b0000) && O[idx];
    assign rise   = active && (hnew == 4'b1111) && !O[idx];
    assign push   = fall || rise;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < Channels; k++) begin
                hist[k] <= 4'b1111;
            end
            O <= '1;
        end else if (active) begin
            hist[idx] <= hnew;
            if (fall) begin
                O[idx] <= 1'b0;
            end else if (rise) begin
                O[idx] <= 1'b1;
            end
        end
    end

    // Event FIFO. A push into a full FIFO is still accepted when the head
    // leaves in the same cycle. An empty FIFO cannot pop, so a push into an
    // empty FIFO is simply stored.
    assign full       = (used == (PtrW + 1)'(FifoDepth));
    assign EventValid = (used != '0);
    assign pop        = EventValid && EventReady;
    assign accept     = push && (!full || pop);
    assign drop       = push && full && !pop;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < FifoDepth; k++) begin
                fifo_ch[k] <= '0;
            end
            fifo_lvl <= '0;
            rdptr    <= '0;
            wrptr    <= '0;
            used     <= '0;
        end else begin
            if (accept) begin
                fifo_ch[wrptr]  <= idx;
                fifo_lvl[wrptr] <= rise;
                wrptr           <= wrptr + PtrW'(1);
            end
            if (pop) begin
                rdptr <= rdptr + PtrW'(1);
            end
            case ({accept, pop})
                2'b10:   used <= used + (PtrW + 1)'(1);
                2'b01:   used <= used - (PtrW + 1)'(1);
                default: used <= used;
            endcase
        end
    end

    // The head is presented as zero while the FIFO is empty.
    assign EventChannel = EventValid ? fifo_ch[rdptr] : '0;
    assign EventLevel   = EventValid ? fifo_lvl[rdptr] : 1'b0;

    // Sticky overflow flag. A drop in the same cycle as a clear keeps it set.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (drop) begin
            Overflow <= 1'b1;
        end else if (OverflowClear) begin
            Overflow <= 1'b0;
        end
    end

endmodule
